// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, init-sequencer states, address bit indices.
package sdram_pkg;

   localparam int unsigned CMD_W   = 4;
   localparam int unsigned A10_BIT = 10;

   typedef logic [CMD_W-1:0] sdram_cmd_t;

   // {cs_n, ras_n, cas_n, we_n}
   localparam sdram_cmd_t CMD_NOP  = 4'b0111;
   localparam sdram_cmd_t CMD_PRE  = 4'b0010;
   localparam sdram_cmd_t CMD_AREF = 4'b0001;
   localparam sdram_cmd_t CMD_MSET = 4'b0000;

   typedef enum logic [2:0] {
      S_WAIT,
      S_PRE,
      S_TRP,
      S_AREF,
      S_TRFC,
      S_MRS,
      S_TMRD,
      S_DONE
   } init_state_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sdram_tcnt.sv
// Loadable saturating down-counter with zero flag; times power-up and inter-command gaps.
module sdram_tcnt #(
   parameter int unsigned W = 8
) (
   input  logic         sclk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero_c
);

   logic [W-1:0] count;

   always_ff @(posedge sclk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - W'(1);
      end
   end

   assign zero_c = (count == '0);

endmodule

// File: rtl/sdram_init_seq.sv
// SDRAM power-up init: wait -> PRECHARGE-ALL -> AREF_NUM x AUTO-REFRESH -> MODE-REGISTER-SET -> done.
// Define SDRAM_INIT_RTMODE_EN to add the mode_cfg port and drive it during MSET instead of MODE_WORD.
module sdram_init_seq
   import sdram_pkg::*;
#(
   parameter int unsigned ADDR_W        = 12,
   parameter int unsigned BA_W          = 2,
   parameter int unsigned T_POWERUP_CYC = 20000,
   parameter int unsigned T_RP_CYC      = 2,
   parameter int unsigned T_RFC_CYC     = 8,
   parameter int unsigned T_MRD_CYC     = 2,
   parameter int unsigned AREF_NUM      = 2,
   parameter logic [ADDR_W-1:0] MODE_WORD = ADDR_W'(12'h032)
) (
   input  logic              sclk,
   input  logic              rst,
   input  logic              reinit_req,
`ifdef SDRAM_INIT_RTMODE_EN
   input  logic [ADDR_W-1:0] mode_cfg,
`endif
   output logic              sdram_cke,
   output logic [CMD_W-1:0]  sdram_cmd,
   output logic [BA_W-1:0]   sdram_ba,
   output logic [ADDR_W-1:0] sdram_addr,
   output logic              init_busy,
   output logic              init_done
);

   if (ADDR_W < 11 || BA_W < 1 || T_POWERUP_CYC < 1 || T_RP_CYC < 1 ||
       T_RFC_CYC < 1 || T_MRD_CYC < 1 || AREF_NUM < 1) begin : g_bad_params
      $error("sdram_init_seq: illegal parameter value");
   end

   localparam int unsigned T_MAX = max_u(max_u(T_POWERUP_CYC, T_RP_CYC),
                                         max_u(T_RFC_CYC, T_MRD_CYC));
   localparam int unsigned DW = $clog2(T_MAX + 1);
   localparam int unsigned RW = $clog2(AREF_NUM + 1);
   localparam logic [ADDR_W-1:0] A10_ADDR = ADDR_W'(1 << A10_BIT);

   init_state_e       state, state_next;
   logic              run;
   logic              cnt_load;
   logic [DW-1:0]     cnt_val;
   logic              cnt_zero_c;
   logic [RW-1:0]     ref_cnt;
   logic              ref_inc, ref_clr;
   sdram_cmd_t        cmd_next;
   logic [ADDR_W-1:0] mode_word;

`ifdef SDRAM_INIT_RTMODE_EN
   assign mode_word = mode_cfg;
`else
   assign mode_word = MODE_WORD;
`endif

   sdram_tcnt #(.W(DW)) u_tcnt (
      .sclk     (sclk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .zero_c   (cnt_zero_c)
   );

   // Next state; a command state is entered for exactly one cycle and arms the following gap.
   always_comb begin
      state_next = state;
      cnt_load   = 1'b0;
      cnt_val    = '0;
      ref_inc    = 1'b0;
      ref_clr    = 1'b0;
      cmd_next   = CMD_NOP;

      case (state)
         S_WAIT: begin
            if (!run) begin
               cnt_load = 1'b1;
               cnt_val  = DW'(T_POWERUP_CYC - 1);
            end else if (cnt_zero_c) begin
               state_next = S_PRE;
            end
         end
         S_PRE, S_TRP:   state_next = cnt_zero_c ? S_AREF : S_TRP;
         S_AREF, S_TRFC: begin
            if (!cnt_zero_c) state_next = S_TRFC;
            else             state_next = (ref_cnt == RW'(AREF_NUM)) ? S_MRS : S_AREF;
         end
         S_MRS, S_TMRD:  state_next = cnt_zero_c ? S_DONE : S_TMRD;
         S_DONE:         if (reinit_req) state_next = S_PRE;
         default:        state_next = S_WAIT;
      endcase

      case (state_next)
         S_PRE: begin
            cmd_next = CMD_PRE;
            cnt_load = 1'b1;
            cnt_val  = DW'(T_RP_CYC - 1);
            ref_clr  = 1'b1;
         end
         S_AREF: begin
            cmd_next = CMD_AREF;
            cnt_load = 1'b1;
            cnt_val  = DW'(T_RFC_CYC - 1);
            ref_inc  = 1'b1;
         end
         S_MRS: begin
            cmd_next = CMD_MSET;
            cnt_load = 1'b1;
            cnt_val  = DW'(T_MRD_CYC - 1);
         end
         default: ;
      endcase
   end

   // State and registered bus outputs; cke trails the first post-reset edge by one cycle.
   always_ff @(posedge sclk) begin
      if (rst) begin
         state      <= S_WAIT;
         run        <= 1'b0;
         ref_cnt    <= '0;
         sdram_cke  <= 1'b0;
         sdram_cmd  <= CMD_NOP;
         sdram_ba   <= '0;
         sdram_addr <= A10_ADDR;
         init_busy  <= 1'b1;
         init_done  <= 1'b0;
      end else begin
         state      <= state_next;
         run        <= 1'b1;
         sdram_cke  <= run;
         sdram_cmd  <= cmd_next;
         sdram_ba   <= '0;
         sdram_addr <= (state_next == S_MRS) ? mode_word : A10_ADDR;
         init_busy  <= (state_next != S_DONE);
         init_done  <= (state_next == S_DONE);
         if (ref_clr)      ref_cnt <= '0;
         else if (ref_inc) ref_cnt <= ref_cnt + RW'(1);
      end
   end

endmodule
